// File: rtl/axi4s_read_data_fifo.sv
`default_nettype none
// ==========================================================================
// axi4s_read_data_fifo: buffers non-stallable read beats into AXI-Stream packets
// Revision: 1.0
// ==========================================================================
module axi4s_read_data_fifo #(
  parameter int DATA_W        = 512,
  parameter int DEPTH         = 16,
  parameter int BEATS_PER_PKT = 1,
  parameter int AF_MARGIN     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_valid,
  input  logic                  flush,
  output logic                  almost_full,
  output logic [$clog2(DEPTH):0] level,
  output logic                  err,
  output logic [15:0]           drop_count,
  output logic [15:0]           latest_buf,
  output logic [DATA_W-1:0]     M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(AF_MARGIN);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS_PER_PKT - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [BW-1:0]     beat_cnt;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign full = (level == FULL_LEVEL);
  assign pop  = M_AXIS_TVALID && M_AXIS_TREADY;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push = rd_valid && !flush && (!full || pop);
  assign drop = rd_valid && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
      drop_count <= '0;
      latest_buf <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        latest_buf <= rd_data[15:0];
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
      if (drop) begin
        err <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rd_data;
    end
  end

  // Data is forced to zero when empty so the idle bus is deterministic.
  assign M_AXIS_TVALID = (level != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? mem[rd_ptr] : '0;
  assign M_AXIS_TLAST  = (beat_cnt == LAST_BEAT);
  assign M_AXIS_TKEEP  = '1;
  assign almost_full   = ((FULL_LEVEL - level) <= AF_LEVEL);

endmodule
`default_nettype wire

// File: tb/tb_axi4s_read_data_fifo.sv
`default_nettype none
// Testbench for axi4s_read_data_fifo: directed table plus multi-cycle sequences.
module tb_axi4s_read_data_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        flush;
  logic        almost_full;
  logic [4:0]  level;
  logic        err;
  logic [15:0] drop_count;
  logic [15:0] latest_buf;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  axi4s_read_data_fifo #(
    .DATA_W(32), .DEPTH(16), .BEATS_PER_PKT(4), .AF_MARGIN(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush),
    .almost_full(almost_full), .level(level), .err(err), .drop_count(drop_count),
    .latest_buf(latest_buf), .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] d;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [4:0]  elev;
    logic [15:0] elb;
  } vec_t;

  vec_t        tbl [17];
  logic [31:0] q [$];
  int          rx_idx;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a negedge after TREADY is set: scores the transfer of the coming edge.
  task automatic sample_pop();
    if (tvalid && tready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got %0h expected none", tdata);
      end else begin
        chk("pop_data", tdata, q.pop_front());
        chk("pop_last", tlast, (rx_idx % 4) == 3);
        rx_idx++;
      end
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rd_valid = 1'b1; rd_data = d; tready = rdy; flush = 1'b0;
    q.push_back(d);
    sample_pop();
  endtask

  task automatic idle(input logic rdy);
    @(negedge clk);
    rd_valid = 1'b0; tready = rdy; flush = 1'b0;
    sample_pop();
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1; rd_valid = 1'b0; tready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    q.delete();
    rx_idx = 0;
  endtask

  task automatic chk_reset();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_level", level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_latest", latest_buf, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_lvl;
    int sent;
    logic prev_stall;
    logic [31:0] prev_d;
    logic prev_l;

    //            rv  d  fl rdy   ev  ed  el lev latest
    tbl[0]  = '{1, 0,  0, 1,   0, 0,  0, 0, 0};
    tbl[1]  = '{1, 1,  0, 1,   1, 0,  0, 1, 0};
    tbl[2]  = '{1, 2,  0, 1,   1, 1,  0, 1, 1};
    tbl[3]  = '{1, 3,  0, 1,   1, 2,  0, 1, 2};
    tbl[4]  = '{0, 0,  0, 1,   1, 3,  1, 1, 3};
    tbl[5]  = '{0, 0,  0, 0,   0, 0,  0, 0, 3};
    tbl[6]  = '{1, 10, 0, 0,   0, 0,  0, 0, 3};
    tbl[7]  = '{1, 11, 0, 0,   1, 10, 0, 1, 10};
    tbl[8]  = '{1, 12, 0, 0,   1, 10, 0, 2, 11};
    tbl[9]  = '{0, 0,  0, 1,   1, 10, 0, 3, 12};
    tbl[10] = '{0, 0,  0, 1,   1, 11, 0, 2, 12};
    tbl[11] = '{0, 0,  0, 0,   1, 12, 0, 1, 12};
    tbl[12] = '{0, 0,  0, 1,   1, 12, 0, 1, 12};
    tbl[13] = '{0, 0,  0, 0,   0, 0,  1, 0, 12};
    tbl[14] = '{1, 20, 0, 0,   0, 0,  1, 0, 12};
    tbl[15] = '{1, 21, 1, 0,   1, 20, 1, 1, 20};
    tbl[16] = '{0, 0,  0, 0,   0, 0,  0, 0, 20};

    rst = 1'b1; rd_valid = 1'b0; rd_data = '0; flush = 1'b0; tready = 1'b0;
    rx_idx = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset();
    chk("tkeep", tkeep, 4'hF);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("tbl_tvalid", tvalid, tbl[i].ev);
      chk("tbl_tdata", tdata, tbl[i].ed);
      chk("tbl_tlast", tlast, tbl[i].el);
      chk("tbl_level", level, tbl[i].elev);
      chk("tbl_latest", latest_buf, tbl[i].elb);
      rd_valid = tbl[i].rv; rd_data = tbl[i].d; flush = tbl[i].fl; tready = tbl[i].rdy;
    end
    @(negedge clk);
    rd_valid = 1'b0; flush = 1'b0;
    chk("tbl_err", err, 0);
    chk("tbl_drop", drop_count, 0);

    // Overflow: 20 beats into a stalled 16-entry FIFO.
    exp_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ovf_level", level, exp_lvl);
      chk("ovf_af", almost_full, exp_lvl >= 12);
      rd_valid = 1'b1; rd_data = 100 + i; tready = 1'b0;
      if (i < 16) q.push_back(100 + i);
      exp_lvl = (exp_lvl < 16) ? exp_lvl + 1 : 16;
    end
    @(negedge clk);
    chk("ovf_full", level, 16);
    chk("ovf_err", err, 1);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_af_full", almost_full, 1);
    // Full with simultaneous pop must accept the new beat.
    rd_valid = 1'b1; rd_data = 200; tready = 1'b1;
    q.push_back(200);
    sample_pop();
    @(negedge clk);
    rd_valid = 1'b0;
    chk("fullpop_level", level, 16);
    chk("fullpop_drop", drop_count, 4);
    chk("fullpop_latest", latest_buf, 200);
    sample_pop();
    for (int c = 0; c < 60 && q.size() != 0; c++) idle(1'b1);
    chk("drain_empty", q.size(), 0);

    // Random backpressure with an issuer that honours almost_full.
    do_flush();
    sent = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stable_data", tdata, prev_d);
        chk("stable_last", tlast, prev_l);
      end
      tready = 1'($urandom_range(0, 1));
      if (sent < 30 && !almost_full) begin
        rd_valid = 1'b1; rd_data = 300 + sent;
        q.push_back(300 + sent);
        sent++;
      end else begin
        rd_valid = 1'b0;
      end
      sample_pop();
      prev_stall = tvalid && !tready; prev_d = tdata; prev_l = tlast;
      if (sent == 30 && q.size() == 0) break;
    end
    chk("rand_sent", sent, 30);
    chk("rand_empty", q.size(), 0);
    chk("rand_drop", drop_count, 4);

    // Flush mid-packet with a same-cycle beat.
    do_flush();
    push_beat(400, 1'b1);
    push_beat(401, 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 5; i++) push_beat(500 + i, 1'b0);
    @(negedge clk);
    flush = 1'b1; rd_valid = 1'b1; rd_data = 600; tready = 1'b0;
    @(negedge clk);
    flush = 1'b0; rd_valid = 1'b0;
    chk("flush_tvalid", tvalid, 0);
    chk("flush_level", level, 0);
    chk("flush_tlast", tlast, 0);
    chk("flush_drop", drop_count, 4);
    chk("flush_latest", latest_buf, 504);
    q.delete();
    rx_idx = 0;
    for (int i = 0; i < 4; i++) push_beat(700 + i, 1'b1);
    for (int c = 0; c < 10 && q.size() != 0; c++) idle(1'b1);
    chk("post_flush_empty", q.size(), 0);
    chk("post_flush_count", rx_idx, 4);

    // Saturate the drop counter, then reset.
    do_flush();
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 32'h1234ABCD; tready = 1'b0;
    repeat (16 + 65540) @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop", drop_count, 16'hFFFF);
    chk("sat_err", err, 1);
    chk("sat_level", level, 16);
    chk("sat_latest", latest_buf, 16'hABCD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4s_read_data_fifo.md
# axi4s_read_data_fifo

Parametrised successor to the single-entry read-data skid stage. It sits between the DDR4 adapter read-return path and the AXI DMA S2MM AXI-Stream input. The block buffers non-stallable `rd_valid` beats in a DEPTH-entry FIFO, raises an advisory almost-full to the command issuer, groups beats into fixed-length packets with TLAST, and counts dropped beats on overflow.

## Interface
- DATA_W, 512, data width in bits; multiple of 8.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- BEATS_PER_PKT, 1, beats per AXI-Stream packet; ≥1; TLAST on last beat.
- AF_MARGIN, 4, almost-full asserts when free entries ≤ AF_MARGIN; < DEPTH.

- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- rd_data  in  DATA_W  read beat from DDR4 adapter.
- rd_valid  in  1  beat valid; cannot be back-pressured.
- flush  in  1  synchronous clear of FIFO contents and packet beat counter.
- almost_full  out  1  advisory to command issuer: stop issuing reads.
- level  out  $clog2(DEPTH)+1  current occupancy.
- err  out  1  sticky overflow flag.
- drop_count  out  16  beats dropped, saturating at 16'hFFFF.
- latest_buf  out  16  rd_data[15:0] of last accepted beat (debug).
- M_AXIS_TDATA  out  DATA_W  stream data.
- M_AXIS_TKEEP  out  DATA_W/8  constant all ones.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  stream ready.

## Operation
- Push: `rd_valid && !flush && (level < DEPTH || pop)`, where pop = `M_AXIS_TVALID && M_AXIS_TREADY`. A push writes rd_data at the write pointer and updates latest_buf.
- Drop: `rd_valid && !flush && level == DEPTH && !pop`. The beat is discarded, err is set to 1 and stays set until rst, and drop_count increments, saturating at 16'hFFFF.
- level updates by +push −pop. Pointers wrap modulo DEPTH.
- Output: M_AXIS_TVALID = (level != 0). M_AXIS_TDATA is the head entry. Once TVALID is asserted, TDATA and TLAST hold until the handshake (AXI-S stability).
- Packet counter beat_cnt runs over 0..BEATS_PER_PKT-1. M_AXIS_TLAST = (beat_cnt == BEATS_PER_PKT-1). beat_cnt increments on pop and wraps to 0 after the last beat. With BEATS_PER_PKT=1, TLAST is always 1.
- almost_full = (DEPTH − level ≤ AF_MARGIN), computed from registered level.
- flush has priority over push and pop in the same cycle. It empties the FIFO (level=0), clears beat_cnt, and discards any same-cycle rd_valid without counting it as a drop. err, drop_count and latest_buf are preserved.
- rst mid-operation discards all contents, including any partial packet, with no TLAST emitted.

## Timing
- Reset values: M_AXIS_TVALID=0, M_AXIS_TLAST=(BEATS_PER_PKT==1), M_AXIS_TDATA=0, level=0, almost_full=0, err=0, drop_count=0, latest_buf=0.
- Latency: beat accepted at edge N produces M_AXIS_TVALID=1 with that data in cycle N+1. There is no combinational path from rd_* to M_AXIS_*.
- Throughput: one push and one pop per cycle sustained; full with simultaneous pop accepts the push.
- level, almost_full, err and drop_count reflect an edge's push/pop in the cycle after that edge.
- M_AXIS_TREADY may toggle arbitrarily; TVALID never depends on TREADY.

## Test plan
- Streaming: TREADY=1, 8 beats with data=i on consecutive cycles, BEATS_PER_PKT=4. Expect outputs 0..7, each one cycle after input; TLAST on beats 3 and 7; level ≤1; err=0.
- Overflow: DEPTH=16, TREADY=0, 20 beats. Expect level=16; almost_full high once level ≥12; err=1; drop_count=4. Then TREADY=1: outputs are 0..15 in order, and beats 16..19 never appear.
- Full with simultaneous pop: level=16, one cycle of rd_valid and TREADY together. Expect no drop, level stays 16, and the new beat appears 16 pops later.
- Backpressure stability: BEATS_PER_PKT=3, random TREADY over 30 beats. TDATA/TLAST are stable while TVALID && !TREADY; TLAST is on every 3rd transferred beat; sequence matches input.
- Flush: 5 beats queued with beat_cnt=2, then flush together with rd_valid. Next cycle TVALID=0, level=0, drop_count unchanged. The next beat has TLAST only after BEATS_PER_PKT beats.
- Saturation and reset: force 70000 drops. Expect drop_count=16'hFFFF, err=1. Assert rst for 1 cycle: all outputs return to their reset values.
